// File: rtl/onewire_pkg.sv
// onewire_pkg: command encodings, state names and slot timing (in ticks)
// shared by the 1-wire sequencer and its prescaler.
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RESET  = 2'd0,
    OP_WRITE8 = 2'd1,
    OP_READ8  = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_SLOT = 2'd1,
    ST_BIT_SLOT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [9:0] T_RST_LOW    = 10'd480;  // reset pulse low time
  localparam logic [9:0] T_RST_SAMPLE = 10'd550;  // presence sample point
  localparam logic [9:0] T_RST_TOTAL  = 10'd960;  // whole reset slot
  localparam logic [9:0] T_SLOT_TOTAL = 10'd70;   // whole bit slot
  localparam logic [9:0] T_LOW_SHORT  = 10'd6;    // write-1 / read init low
  localparam logic [9:0] T_LOW_LONG   = 10'd60;   // write-0 low
  localparam logic [9:0] T_RD_SAMPLE  = 10'd14;   // read sample point

  // Index of the final tick of a slot lasting 'total' ticks.
  function automatic logic [9:0] last_tick(input logic [9:0] total);
    return total - 10'd1;
  endfunction

endpackage

// File: rtl/onewire_tick.sv
// onewire_tick: free-running prescaler emitting a one-cycle tick every
// tck_mask+1 clocks (tck_mask is a power of two minus one).
module onewire_tick #(
  parameter int unsigned tck_mask = 31
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] MASK = 16'(tck_mask);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        tick_q;

  // Next prescaler value wraps naturally through the mask.
  always_comb begin
    cnt_d = (cnt_q + 16'd1) & MASK;
  end

  // Prescaler count and registered tick strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == MASK);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/onewire_seq.sv
// onewire_seq: 1-wire bus master running RESET / WRITE8 / READ8 / NOP
// commands as tick-timed slots on an open-drain line.
module onewire_seq
  import onewire_pkg::*;
#(
  parameter int unsigned tck_mask = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       busy,
  inout  wire        DS1
);

  state_e     state_q, state_d;
  op_e        op_q;
  logic [7:0] data_q;
  logic [7:0] sh_q;
  logic [7:0] rsp_data_q;
  logic [9:0] tcnt_q;
  logic [2:0] bit_q;
  logic       oe_q;
  logic       pres_q;

  logic       tick_s;
  logic       accept_s;
  logic       in_slot_s;
  logic       at_end_s;
  logic       drive_s;
  logic       ds1_in_s;
  logic [9:0] slot_last_s;
  logic [9:0] low_len_s;

  onewire_tick #(.tck_mask(tck_mask)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Open drain: only ever pull low, straight from a register.
  assign DS1      = oe_q ? 1'b0 : 1'bz;
  assign ds1_in_s = DS1;

  // Slot bookkeeping: final tick index, low duration and line drive for this tick.
  always_comb begin
    in_slot_s = (state_q == ST_RST_SLOT) || (state_q == ST_BIT_SLOT);
    if (state_q == ST_RST_SLOT) begin
      slot_last_s = last_tick(T_RST_TOTAL);
      low_len_s   = T_RST_LOW;
    end else if ((op_q == OP_WRITE8) && !data_q[bit_q]) begin
      slot_last_s = last_tick(T_SLOT_TOTAL);
      low_len_s   = T_LOW_LONG;
    end else begin
      slot_last_s = last_tick(T_SLOT_TOTAL);
      low_len_s   = T_LOW_SHORT;
    end
    at_end_s = tick_s && in_slot_s && (tcnt_q == slot_last_s);
    drive_s  = in_slot_s && (tcnt_q < low_len_s);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: dispatch on accepted op, leave slots on their final tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_RESET:  state_d = ST_RST_SLOT;
            OP_WRITE8: state_d = ST_BIT_SLOT;
            OP_READ8:  state_d = ST_BIT_SLOT;
            default:   state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RST_SLOT: begin
        if (at_end_s) state_d = ST_DONE;
        else          state_d = ST_RST_SLOT;
      end
      ST_BIT_SLOT: begin
        if (at_end_s && (bit_q == 3'd7)) state_d = ST_DONE;
        else                             state_d = ST_BIT_SLOT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_DONE);
    accept_s  = cmd_valid && (state_q == ST_IDLE);
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_presence = pres_q;

  // Datapath: latch command, count ticks, drive/sample the line, collect the read byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NOP;
      data_q     <= 8'h00;
      sh_q       <= 8'h00;
      rsp_data_q <= 8'h00;
      tcnt_q     <= 10'd0;
      bit_q      <= 3'd0;
      oe_q       <= 1'b0;
      pres_q     <= 1'b0;
    end else if (accept_s) begin
      op_q   <= op_e'(cmd_op);
      data_q <= cmd_data;
      sh_q   <= 8'h00;
      tcnt_q <= 10'd0;
      bit_q  <= 3'd0;
    end else if (tick_s && in_slot_s) begin
      oe_q   <= drive_s;
      tcnt_q <= at_end_s ? 10'd0 : (tcnt_q + 10'd1);
      if ((state_q == ST_RST_SLOT) && (tcnt_q == T_RST_SAMPLE)) begin
        pres_q <= !ds1_in_s;
      end
      if ((state_q == ST_BIT_SLOT) && (op_q == OP_READ8) && (tcnt_q == T_RD_SAMPLE)) begin
        sh_q <= {ds1_in_s, sh_q[7:1]};
      end
      if ((state_q == ST_BIT_SLOT) && at_end_s) begin
        bit_q <= bit_q + 3'd1;
        if ((bit_q == 3'd7) && (op_q == OP_READ8)) begin
          rsp_data_q <= sh_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_seq.sv
// tb_onewire_seq: table-driven and randomized checks of onewire_seq with a
// pulled-up line, a simple presence responder and a read-slot responder.
module tb_onewire_seq;

  localparam int TCK = 8;  // clocks per tick with tck_mask = 7

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       busy;
  tri1        DS1;

  logic tb_pull = 1'b0;
  assign DS1 = tb_pull ? 1'b0 : 1'bz;

  onewire_seq #(.tck_mask(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .busy         (busy),
    .DS1          (DS1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side line environment
  int   cyc = 0;
  int   vcount = 0;
  int   pw_q[$];
  int   ps_q[$];
  int   low_run = 0;
  logic ds_prev_high = 1'b1;
  bit   rd_mode = 1'b0;
  logic [7:0] rd_pat = 8'h00;
  int   rd_slot = 0;
  bit   dev_on = 1'b0;
  int   pull_cnt = 0;
  int   wait_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: records low pulses, emulates a presence-capable device and read responses.
  always @(negedge clk) begin
    logic cur_low;
    cur_low = (DS1 === 1'b0);
    if (rsp_valid === 1'b1) vcount++;
    if (!rd_mode) rd_slot = 0;
    if (pull_cnt > 0) begin
      pull_cnt--;
      if (pull_cnt == 0) tb_pull = 1'b0;
    end
    if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        tb_pull  = 1'b1;
        pull_cnt = 150 * TCK;
      end
    end
    if (cur_low) begin
      if (ds_prev_high) begin
        ps_q.push_back(cyc);
        low_run = 0;
        if (rd_mode) begin
          if (rd_slot < 8 && rd_pat[rd_slot] == 1'b0) begin
            tb_pull  = 1'b1;
            pull_cnt = 31 * TCK;
          end
          rd_slot++;
        end
      end
      low_run++;
    end else if (!ds_prev_high) begin
      pw_q.push_back(low_run);
      if (dev_on && low_run >= 400 * TCK) wait_cnt = 30 * TCK;
    end
    ds_prev_high = !cur_low;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  // Present a command (call just after a negedge); returns after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, output bit ok);
    int n;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid; flags any cycle where the sequencer looked idle meanwhile.
  task automatic wait_rsp(input int max, output int lat, output bit bad);
    lat = 0; bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (rsp_valid !== 1'b1 && (cmd_ready !== 1'b0 || busy !== 1'b1)) bad = 1'b1;
    end while (rsp_valid !== 1'b1 && lat < max);
  endtask

  // Expected write pulses: LSB first, 6 ticks for a 1, 60 for a 0, starts 70 ticks apart.
  task automatic chk_pulses(input string nm, input logic [7:0] d, input int wb, input int sb);
    chk({nm, " pulse count"}, pw_q.size() - wb, 8);
    for (int i = 0; i < 8; i++)
      if (wb + i < pw_q.size())
        chk($sformatf("%s width%0d", nm, i), pw_q[wb + i], d[i] ? 6 * TCK : 60 * TCK);
    for (int i = 1; i < 8; i++)
      if (sb + i < ps_q.size())
        chk($sformatf("%s spacing%0d", nm, i), ps_q[sb + i] - ps_q[sb + i - 1], 70 * TCK);
  endtask

  task automatic do_cmd(input string nm, input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] pat, input bit dev,
                        input logic [7:0] e_data, input logic e_pres);
    int lat, v0, wb, sb, exp_lat;
    bit ok, bad;
    rd_mode = (op == 2'd2); rd_pat = pat; dev_on = dev;
    wb = pw_q.size(); sb = ps_q.size(); v0 = vcount;
    issue(op, d, ok);
    chk({nm, " accepted"}, ok, 1'b1);
    wait_rsp(9000, lat, bad);
    exp_lat = (op == 2'd0) ? 960 * TCK : 560 * TCK;
    if (op == 2'd3) chk({nm, " latency"}, lat, 1);
    else            chk_rng({nm, " latency"}, lat, exp_lat - 8, exp_lat + 8);
    chk({nm, " busy while active"}, bad, 1'b0);
    repeat (4) @(negedge clk);
    chk({nm, " rsp_valid count"}, vcount - v0, 1);
    chk({nm, " rsp_data"}, rsp_data, e_data);
    chk({nm, " rsp_presence"}, rsp_presence, e_pres);
    if (op == 2'd1) chk_pulses(nm, d, wb, sb);
    rd_mode = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] pat;
    bit         dev;
    logic [7:0] e_data;
    logic       e_pres;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] m_data;
  logic       m_pres;

  initial begin
    int lat, v0, wb, sb, n;
    bit ok, bad;
    logic [1:0] rop;
    logic [7:0] rd, rp;
    bit rdev;

    tbl[0] = '{2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};  // NOP from reset
    tbl[1] = '{2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};  // RESET, no device
    tbl[2] = '{2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};  // RESET, device answers
    tbl[3] = '{2'd1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b1};  // WRITE8 0xA5
    tbl[4] = '{2'd2, 8'h00, 8'hC3, 1'b0, 8'hC3, 1'b1};  // READ8 0xC3
    tbl[5] = '{2'd3, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b1};  // NOP holds data
    tbl[6] = '{2'd2, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b1};  // READ8 0x5A
    tbl[7] = '{2'd1, 8'h3C, 8'h00, 1'b0, 8'h5A, 1'b1};  // WRITE8 holds data

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset DS1 released", DS1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_data", rsp_data, 8'h00);
    chk("reset rsp_presence", rsp_presence, 1'b0);

    for (int i = 0; i < 8; i++)
      do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, tbl[i].pat, tbl[i].dev,
             tbl[i].e_data, tbl[i].e_pres);
    m_data = tbl[7].e_data;
    m_pres = tbl[7].e_pres;

    // cmd_valid held across RESET then WRITE8 0xCC
    rd_mode = 1'b0; dev_on = 1'b1; v0 = vcount;
    cmd_op = 2'd0; cmd_data = 8'h00; cmd_valid = 1'b1;
    chk("b2b ready before", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_op = 2'd1; cmd_data = 8'hCC;
    wait_rsp(9000, lat, bad);
    chk_rng("b2b reset latency", lat, 960 * TCK - 8, 960 * TCK + 8);
    chk("b2b ready low during reset", bad, 1'b0);
    m_pres = 1'b1;
    chk("b2b presence", rsp_presence, m_pres);
    wb = pw_q.size(); sb = ps_q.size();
    @(negedge clk);
    chk("b2b ready after rsp", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(9000, lat, bad);
    chk_rng("b2b write latency", lat, 560 * TCK - 8, 560 * TCK + 8);
    chk("b2b busy during write", bad, 1'b0);
    repeat (4) @(negedge clk);
    chk("b2b rsp_valid count", vcount - v0, 2);
    chk("b2b rsp_data", rsp_data, m_data);
    chk_pulses("b2b", 8'hCC, wb, sb);
    dev_on = 1'b0;

    // randomized commands against the behavioural model
    for (int k = 0; k < 3; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rd   = 8'($urandom);
      rp   = 8'($urandom);
      rdev = 1'($urandom);
      if (rop == 2'd0) m_pres = rdev;
      if (rop == 2'd2) m_data = rp;
      do_cmd($sformatf("rand%0d op%0d", k, rop), rop, rd, rp, rdev, m_data, m_pres);
    end

    // reset during the low phase of bit 0 of WRITE8 0x00
    issue(2'd1, 8'h00, ok);
    chk("abort accepted", ok, 1'b1);
    n = 0;
    while (DS1 !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort slot started", n < 50, 1'b1);
    repeat (20) @(negedge clk);
    chk("abort line low before rst", DS1, 1'b0);
    v0 = vcount; sb = ps_q.size();
    rst = 1'b1;
    #1;
    chk("abort DS1 released at once", DS1, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort cmd_ready", cmd_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    repeat (600) @(negedge clk);
    chk("abort no rsp_valid", vcount - v0, 0);
    chk("abort no replay", ps_q.size() - sb, 0);
    m_data = 8'h00; m_pres = 1'b0;
    do_cmd("abort then NOP", 2'd3, 8'h00, 8'h00, 1'b0, m_data, m_pres);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/onewire_seq.md
ONEWIRE_SEQ -- requirements
Module: onewire_seq

Interface
REQ-001 SHALL have parameter tck_mask, default 31, meaning clocks per 1-wire tick minus 1 (power of two minus 1; tick nominally 1 us).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  requester presents a command.
REQ-005 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port cmd_op  input  2  0=RESET, 1=WRITE8, 2=READ8, 3=reserved NOP.
REQ-007 SHALL have port cmd_data  input  8  byte for WRITE8.
REQ-008 SHALL have port rsp_valid  output  1  one-cycle completion strobe.
REQ-009 SHALL have port rsp_data  output  8  byte assembled by READ8.
REQ-010 SHALL have port rsp_presence  output  1  presence pulse detected by the last RESET.
REQ-011 SHALL have port busy  output  1  transaction in progress.
REQ-012 SHALL have port DS1  inout  1  open-drain 1-wire line: drives 0 or z, never 1.

Function
REQ-013 SHALL generate a one-cycle tick every tck_mask+1 clocks from a free-running prescaler; all slot timing counts ticks.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&cmd_ready, and op/data are latched that cycle.
REQ-015 SHALL use states IDLE, RST_SLOT, BIT_SLOT, DONE. IDLE->RST_SLOT on RESET; IDLE->BIT_SLOT on WRITE8/READ8; IDLE->DONE on NOP. Slot ends->BIT_SLOT (next bit) or DONE. DONE->IDLE after one cycle.
REQ-016 SHALL start slot tick count at 0 on the first tick after acceptance; a 10-bit counter holds the tick count.
REQ-017 RESET slot: DS1 low ticks 0-479, released 480-959; DS1 sampled at tick 550; rsp_presence <= (sample==0); 960 ticks total.
REQ-018 WRITE8: 8 slots, LSB first, 70 ticks each; bit 1 low ticks 0-5; bit 0 low ticks 0-59.
REQ-019 READ8: 8 slots, 70 ticks each, low ticks 0-5, DS1 sampled at tick 14 and shifted in LSB first; rsp_data updated only at READ8 completion.
REQ-020 SHALL assert rsp_valid for exactly one cycle, in DONE, i.e. the cycle after the final slot tick (NOP: the cycle after acceptance).
REQ-021 rsp_data SHALL hold its value across RESET/WRITE8/NOP; rsp_presence SHALL hold across non-RESET commands.
REQ-022 busy SHALL equal !cmd_ready; back-to-back command accepted no earlier than the cycle after rsp_valid.
REQ-023 DS1 output enable SHALL come straight from a register, no combinational path from cmd inputs.

Reset
REQ-024 On rst: state=IDLE, DS1 released (z) asynchronously, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00, rsp_presence=0, prescaler and counters 0.
REQ-025 rst mid-transaction SHALL abort with no rsp_valid; the aborted command is not replayed.

Structure
REQ-026 Op encodings and slot timing constants (480, 550, 960, 70, 6, 60, 14) SHALL live in shared package onewire_pkg.
REQ-027 Prescaler SHALL be sub-module onewire_tick (clk, rst, tck_mask param, tick out); all else in onewire_seq.
REQ-028 Target 150-300 lines RTL total.

Verification (tck_mask=7, DS1 pulled up by tri1)
REQ-029 RESET, no device -> rsp_presence=0, rsp_valid 960*8 (+/- 8) clocks after accept; existing ds1822 chip model attached -> rsp_presence=1.
REQ-030 WRITE8 0xA5 -> DS1 low widths 6,60,6,60,60,6,60,6 ticks (x8 clocks), slot starts 70 ticks apart, one rsp_valid.
REQ-031 READ8 with bench pulling DS1 low ticks 0-30 in slots for 0-bits of 0xC3 -> rsp_data=0xC3, rsp_presence unchanged.
REQ-032 cmd_valid held across RESET then WRITE8 0xCC -> second accepted the cycle after first rsp_valid; cmd_ready low throughout first.
REQ-033 rst pulsed during bit-0 low phase of WRITE8 0x00 -> DS1 z in same cycle, no rsp_valid, cmd_ready=1 after release; subsequent NOP -> rsp_valid next cycle.
